// File: rtl/haz_monitor.sv
// haz_monitor: watches the hazard lamp bus, measures the time between lamp
// transitions, and reports blink lock, cadence/stuck errors and mixed patterns.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   lamps        lamp bus under observation
//   clr          synchronous clear of the sticky fault flag
//   active       a valid blink is locked
//   timing_err   one-cycle pulse on cadence violation or stuck-on lamps
//   fault        sticky flag, set on a mixed (partial) lamp pattern
//   half_period  last measured edge-to-edge interval
module haz_monitor #(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned HALF   = 501,
   parameter int unsigned TOL    = 4,
   parameter int unsigned LOCK_N = 2,
   parameter int unsigned CW     = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] lamps,
   input  logic             clr,
   output logic             active,
   output logic             timing_err,
   output logic             fault,
   output logic [CW-1:0]    half_period
);

   localparam int unsigned GW  = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
   localparam logic [CW-1:0] LO  = CW'(HALF - TOL);
   localparam logic [CW-1:0] HI  = CW'(HALF + TOL);
   localparam logic [CW-1:0] TMO = CW'(HALF + TOL + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lamps_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    good_q, good_d;
   logic             active_q, active_d;
   logic             terr_q, terr_d;
   logic             fault_q, fault_d;
   logic [CW-1:0]    hp_q, hp_d;

   logic             lamp_edge;
   logic             in_range;
   logic             timeout;
   logic             prev_zero;
   logic             now_zero;
   logic             mixed;
   logic [GW-1:0]    good_inc;

   // Edge / interval qualification against the previous sample.
   assign lamp_edge = (lamps != lamps_q);
   assign in_range  = (cnt_q >= LO) && (cnt_q <= HI);
   assign timeout   = !lamp_edge && (cnt_q == TMO);
   assign prev_zero = (lamps_q == '0);
   assign now_zero  = (lamps == '0);
   assign mixed     = !now_zero && (lamps != '1);
   assign good_inc  = good_q + GW'(1);

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         lamps_q  <= '0;
         cnt_q    <= '0;
         good_q   <= '0;
         active_q <= 1'b0;
         terr_q   <= 1'b0;
         fault_q  <= 1'b0;
         hp_q     <= '0;
      end else begin
         state_q  <= state_d;
         lamps_q  <= lamps;
         cnt_q    <= cnt_d;
         good_q   <= good_d;
         active_q <= active_d;
         terr_q   <= terr_d;
         fault_q  <= fault_d;
         hp_q     <= hp_d;
      end
   end

   // Next-state and registered-output decisions.
   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      active_d = active_q;
      terr_d   = 1'b0;
      hp_d     = hp_q;
      fault_d  = fault_q;
      cnt_d    = '0;

      if (lamp_edge) begin
         cnt_d = CW'(1);
      end else if (state_q != IDLE) begin
         cnt_d = cnt_q + CW'(1);
      end

      if (lamp_edge && (state_q != IDLE)) begin
         hp_d = cnt_q;
      end

      case (state_q)
         IDLE: begin
            if (lamp_edge) begin
               state_d = MEASURE;
               good_d  = '0;
            end
         end
         MEASURE: begin
            if (lamp_edge) begin
               if (in_range) begin
                  good_d = good_inc;
                  if (good_inc == GW'(LOCK_N)) begin
                     state_d  = LOCKED;
                     active_d = 1'b1;
                  end
               end else begin
                  terr_d = 1'b1;
                  good_d = '0;
               end
            end else if (timeout) begin
               // Lamps frozen off means the blinker stopped; frozen on is a fault.
               state_d = IDLE;
               terr_d  = !prev_zero;
               cnt_d   = '0;
            end
         end
         LOCKED: begin
            if (lamp_edge) begin
               if (!in_range) begin
                  active_d = 1'b0;
                  if (now_zero) begin
                     // Blinker disabled: lamps forced off early, not an error.
                     state_d = IDLE;
                  end else begin
                     terr_d  = 1'b1;
                     state_d = MEASURE;
                     good_d  = '0;
                  end
               end
            end else if (timeout) begin
               active_d = 1'b0;
               state_d  = IDLE;
               terr_d   = !prev_zero;
               cnt_d    = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Set takes priority over clear.
      if (clr) begin
         fault_d = 1'b0;
      end
      if (mixed) begin
         fault_d = 1'b1;
      end
   end

   assign active      = active_q;
   assign timing_err  = terr_q;
   assign fault       = fault_q;
   assign half_period = hp_q;

endmodule

// File: doc/haz_monitor.md
# haz_monitor

Lamp-bus monitor for the hazard blinker. It samples the 6-bit hazard lamp outputs and measures the time between lamp transitions. It reports whether a valid hazard blink is running, when the blink cadence is wrong or the lamps are stuck, and when the lamps show a mixed (partial) pattern. It sits on the lamp bus beside the blinker, in the same clock domain, and feeds the dashboard status logic.

## Interface
- `WIDTH`, 6: lamp bus width.
- `HALF`, 501: nominal cycles between lamp toggles. The blinker toggles once every 501 clocks.
- `TOL`, 4: allowed deviation of a measured interval from `HALF`, in cycles.
- `LOCK_N`, 2: consecutive in-range intervals required to declare the blink active.
- `CW`, 10: interval counter width. `CW` must satisfy 2^CW > `HALF`+`TOL`+1.
- `clk` input 1: single clock. All logic is rising-edge.
- `rst` input 1: asynchronous, active-low reset. Asserted when 0.
- `lamps` input `WIDTH`: lamp bus under observation.
- `clr` input 1: synchronous clear of the sticky `fault` flag.
- `active` output 1: a valid blink is locked.
- `timing_err` output 1: one-cycle pulse on a cadence violation or stuck-on lamps.
- `fault` output 1: sticky flag. Set when a mixed lamp pattern is sampled.
- `half_period` output `CW`: last measured edge-to-edge interval.

## Operation
- Internal registers:
  - `lamps_q`, `WIDTH` bits: previous lamp sample.
  - `cnt`, `CW` bits: cycles since the last edge.
  - `good`: count of in-range intervals. 0..`LOCK_N`, saturating.
  - `state`: one of IDLE, MEASURE, LOCKED.
- Edge: the condition `lamps != lamps_q` at a rising clock. `lamps_q <= lamps` on every clock.
- In-range: the test `HALF-TOL <= cnt <= HALF+TOL`, evaluated at an edge.
- Timeout: `cnt == HALF+TOL+1` with no edge in that cycle.
- Counter: `cnt <= 1` on any edge in any state. Otherwise `cnt` increments in MEASURE and LOCKED. It holds 0 in IDLE.
- `half_period <= cnt` on every edge in MEASURE or LOCKED. It is unchanged otherwise.
- IDLE:
  - Edge: go to MEASURE with `good <= 0`.
- MEASURE:
  - Edge in-range: `good <= good+1`. If `good+1 == LOCK_N`, go to LOCKED and set `active <= 1`.
  - Edge out of range: pulse `timing_err`, `good <= 0`, stay in MEASURE.
  - Timeout with `lamps_q` all-0: go to IDLE silently (blinker stopped).
  - Timeout with `lamps_q` nonzero: pulse `timing_err` and go to IDLE.
- LOCKED:
  - Edge in-range: stay.
  - Edge out of range, new sample all-0: go to IDLE with `active <= 0` and no error. This is a normal disable, since the blinker forces lamps off when disabled.
  - Edge out of range, otherwise: pulse `timing_err`, `active <= 0`, go to MEASURE with `good <= 0`.
  - Timeout: `active <= 0` and go to IDLE. Pulse `timing_err` only if `lamps_q` is nonzero (stuck on).
- Fault: `fault <= 1` in any cycle where `lamps` is neither all-0 nor all-1. It stays set until `clr` or reset.
  - Fault detection does not affect the FSM.
  - `clr` and a mixed sample in the same cycle: the set wins, so `fault` stays 1.

## Timing
- Reset (`rst` = 0) forces, immediately and asynchronously:
  - state IDLE, `cnt` = 0, `good` = 0, `lamps_q` = 0;
  - `active` = 0, `timing_err` = 0, `fault` = 0, `half_period` = 0.
- Reset mid-blink discards all measurement. After release, the first edge only arms MEASURE.
- All outputs are registered. Each output reflects the decision one cycle after the clock edge that sampled the triggering `lamps` value.
- `timing_err` is high for exactly one cycle per violation. It is never high two cycles in a row unless two violations occur on consecutive edges.
- Lock latency from IDLE is `LOCK_N`+1 edges. With the defaults, `active` rises 1 cycle after the third edge, i.e. about 1002 cycles after the first toggle.
- Release of reset with `lamps` nonzero: the first clock sees an edge against `lamps_q` = 0. That edge arms MEASURE. This is intended.

## Test plan
- Nominal lock: toggle `lamps` 000000↔111111 every 501 cycles.
  - Required: `active` = 1 one cycle after the 3rd edge.
  - Required: `half_period` = 501, `timing_err` never pulses.
- Tolerance bounds: from LOCKED, apply intervals of 497 and then 505.
  - Required: stays LOCKED.
  - Next apply an interval of 496: one `timing_err` pulse, `active` = 0, `half_period` = 496.
- Normal disable: while LOCKED with lamps at 111111, force 000000 after 200 cycles.
  - Required: `active` = 0, no `timing_err`, state IDLE.
- Stuck-on: while LOCKED, hold 111111 for 506 cycles.
  - Required: one `timing_err` pulse, `active` = 0.
  - Held at 000000 instead: `active` = 0 with no pulse.
- Mixed pattern and clear: drive 000111 for 1 cycle.
  - Required: `fault` = 1 on the next cycle, and it stays set.
  - `clr` with lamps all-0 clears `fault`; `clr` with 001000 present keeps it at 1.
- Async reset mid-lock: pull `rst` low between clock edges.
  - Required: all outputs 0 at once, without waiting for a clock.
  - After release, relock needs 3 fresh edges.
